// File: rtl/nes_i2c_pkg.sv
// nes_i2c_pkg: shared definitions for the NES-controller I2C target.
//   i2c_state_e   : bus-side protocol states of nes_i2c_target
//   NES_I2C_ADDR  : default 7-bit address of the adapter (also used by nes_bridge)
//   I2C_ACK/NACK  : bit values of the acknowledge slot on the wire
package nes_i2c_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    WR_DATA   = 3'd3,
    WR_ACK    = 3'd4,
    RD_DATA   = 3'd5,
    RD_ACK    = 3'd6,
    WAIT_STOP = 3'd7
  } i2c_state_e;

  localparam logic [6:0] NES_I2C_ADDR = 7'h52;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/nes_i2c_line_sync.sv
// i2c_line_sync: input synchronisers for SCL/SDA plus edge and bus-condition
// pulses, all derived from the synchronised levels.
//   clk, rst_n     : system clock, asynchronous active-low reset
//   scl_i, sda_i   : raw pin levels
//   sda_o          : synchronised SDA level
//   scl_rise_o     : one-cycle pulse, synchronised SCL went 0->1
//   scl_fall_o     : one-cycle pulse, synchronised SCL went 1->0
//   start_o        : one-cycle pulse, SDA fell while SCL stayed high
//   stop_o         : one-cycle pulse, SDA rose while SCL stayed high
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  logic                   scl_s;
  logic                   sda_s;

  // Everything resets to 1 so that a reset looks like an idle bus and no
  // spurious edge or START/STOP is seen when reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];
  assign sda_o = sda_s;

  assign scl_rise_o = scl_s & ~scl_prev_q;
  assign scl_fall_o = ~scl_s & scl_prev_q;

  // SCL must be high on both samples so an SDA change coincident with an SCL
  // edge is not mistaken for a bus condition.
  assign start_o = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_o  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/nes_i2c_target.sv
// nes_i2c_target: I2C target emulating the NES-controller adapter. Supports a
// pointer write (first data byte after the address) and sequential reads with
// an auto-incrementing, wrapping byte pointer. Never stretches SCL.
//   clk, rst_n  : system clock (>= 16x SCL), asynchronous active-low reset
//   scl, sda_in : bus levels as seen on the pins
//   sda_oe      : 1 = pull SDA low, 0 = release
//   data_in     : NUM_BYTES button bytes, byte k at [8k+7:8k]
//   ptr         : current byte pointer
//   busy        : high from the address match until the transfer ends
//   byte_sent   : one-cycle pulse after the initiator's ACK/NACK of a read byte
//   dbg_state   : current protocol state (i2c_state_e encoding)
module nes_i2c_target
  import nes_i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = NES_I2C_ADDR,
  parameter int         NUM_BYTES   = 4,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         scl,
  input  logic                         sda_in,
  output logic                         sda_oe,
  input  logic [8*NUM_BYTES-1:0]       data_in,
  output logic [$clog2(NUM_BYTES)-1:0] ptr,
  output logic                         busy,
  output logic                         byte_sent,
  output logic [2:0]                   dbg_state
);

  localparam int PTR_W = $clog2(NUM_BYTES);

  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  i2c_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_line_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (scl),
    .sda_i     (sda_in),
    .sda_o     (sda_s),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall),
    .start_o   (start_det),
    .stop_o    (stop_det)
  );

  i2c_state_e       state_q,     state_d;
  logic [3:0]       bit_cnt_q,   bit_cnt_d;
  logic [7:0]       rx_q,        rx_d;
  logic [7:0]       tx_q,        tx_d;
  logic             rw_q,        rw_d;
  logic             ptr_wr_q,    ptr_wr_d;   // next written byte loads ptr
  logic [PTR_W-1:0] ptr_q,       ptr_d;
  logic             sda_oe_q,    sda_oe_d;
  logic             busy_q,      busy_d;
  logic             byte_sent_q, byte_sent_d;

  logic [7:0]       rx_byte;
  logic [PTR_W-1:0] ptr_inc;

  assign rx_byte = {rx_q[6:0], sda_s};
  assign ptr_inc = ptr_q + 1'b1;   // NUM_BYTES is a power of 2: wraps naturally

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    rw_d        = rw_q;
    ptr_wr_d    = ptr_wr_q;
    ptr_d       = ptr_q;
    sda_oe_d    = sda_oe_q;
    byte_sent_d = 1'b0;

    // Bus conditions override any SCL-edge activity in the same cycle.
    if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE, WAIT_STOP: begin
          sda_oe_d = 1'b0;
        end

        ADDR: begin
          if (scl_rise) begin
            rx_d = rx_byte;
            if (bit_cnt_q == 4'd7) begin
              // rx_q[6:0] holds the address, the bit arriving now is R/W.
              bit_cnt_d = '0;
              rw_d      = sda_s;
              if (rx_q[6:0] == TARGET_ADDR) begin
                state_d = ADDR_ACK;
                if (sda_s) tx_d = data_in[{ptr_q, 3'b000} +: 8];
              end else begin
                state_d = WAIT_STOP;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end

        // ACK slots: the first fall after entry starts driving ACK, the
        // second fall (sda_oe already set) ends the ACK bit.
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = ~I2C_ACK;
            end else if (rw_q) begin
              state_d   = RD_DATA;
              sda_oe_d  = ~tx_q[7];
              tx_d      = {tx_q[6:0], 1'b1};
              bit_cnt_d = 4'd1;
            end else begin
              state_d   = WR_DATA;
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              ptr_wr_d  = 1'b1;
            end
          end
        end

        WR_DATA: begin
          if (scl_rise) begin
            rx_d = rx_byte;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              state_d   = WR_ACK;
              if (ptr_wr_q) begin
                ptr_d    = rx_byte[PTR_W-1:0];
                ptr_wr_d = 1'b0;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end

        WR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = ~I2C_ACK;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = WR_DATA;
            end
          end
        end

        // bit_cnt counts bits already placed on SDA; the fall after the
        // eighth bit releases the line for the initiator's ACK.
        RD_DATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = RD_ACK;
            end else begin
              sda_oe_d  = ~tx_q[7];
              tx_d      = {tx_q[6:0], 1'b1};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end

        RD_ACK: begin
          if (scl_rise) begin
            byte_sent_d = 1'b1;
            ptr_d       = ptr_inc;
            if (sda_s == I2C_ACK) begin
              tx_d      = data_in[{ptr_inc, 3'b000} +: 8];
              bit_cnt_d = '0;
              state_d   = RD_DATA;
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end

        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end

    // busy reflects an accepted address, so a mismatched address never
    // raises it even though the address byte itself is being shifted.
    busy_d = (state_d == ADDR_ACK) || (state_d == WR_DATA) || (state_d == WR_ACK) ||
             (state_d == RD_DATA)  || (state_d == RD_ACK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      rw_q        <= 1'b0;
      ptr_wr_q    <= 1'b0;
      ptr_q       <= '0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      byte_sent_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      rw_q        <= rw_d;
      ptr_wr_q    <= ptr_wr_d;
      ptr_q       <= ptr_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      byte_sent_q <= byte_sent_d;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign ptr       = ptr_q;
  assign busy      = busy_q;
  assign byte_sent = byte_sent_q;
  assign dbg_state = state_q;

endmodule
